// File: rtl/sme_req_seq.sv
// Request sequencer for the SME string-matching engine: buffers one string and one pattern from the host,
// streams them into SME and returns the result. Optional watchdog in WAIT enabled by `SME_TIMEOUT_EN.
module sme_req_seq #(
  parameter int STR_MAX        = 32,
  parameter int PAT_MAX        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       host_wr,
  input  logic       host_sel,
  input  logic [7:0] host_char,
  input  logic       host_last,
  output logic       host_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  localparam int LMAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int SAW  = $clog2(STR_MAX);
  localparam int PAW  = $clog2(PAT_MAX);

  // Buffer addressing slices the length counters, so depths must be powers of two.
  if (TIMEOUT_CYCLES < 1 || (STR_MAX & (STR_MAX - 1)) != 0 || (PAT_MAX & (PAT_MAX - 1)) != 0) begin : g_bad_cfg
    $error("sme_req_seq: unsupported parameter combination");
  end

  typedef enum logic [2:0] {LOAD, SEND_STR, SEND_PAT, WAIT, RESULT} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   str_len, str_len_nxt, pat_len, pat_len_nxt, idx, idx_nxt;
  logic            str_new, str_new_nxt, str_closed, str_closed_nxt;
  logic [7:0]      str_mem [STR_MAX];
  logic [7:0]      pat_mem [PAT_MAX];
  logic            host_ready_nxt, isstring_nxt, ispattern_nxt;
  logic [7:0]      chardata_nxt;
  logic            res_valid_nxt, res_match_nxt, res_timeout_nxt;
  logic [4:0]      res_index_nxt;
  logic            str_acc, pat_acc, str_wr, pat_wr;
  logic [LW-1:0]   str_base;

`ifdef SME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt, cnt_nxt;
`endif

  assign str_acc  = host_wr & host_ready & ~host_sel;
  assign pat_acc  = host_wr & host_ready & host_sel;
  // A write after a closed string starts a fresh one at index 0.
  assign str_base = str_closed ? '0 : str_len;
  assign str_wr   = str_acc & (str_base < LW'(STR_MAX));
  assign pat_wr   = pat_acc & (pat_len < LW'(PAT_MAX));

  always_ff @(posedge clk) begin
    if (str_wr) str_mem[str_base[SAW-1:0]] <= host_char;
    if (pat_wr) pat_mem[pat_len[PAW-1:0]] <= host_char;
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    str_len_nxt     = str_len;
    pat_len_nxt     = pat_len;
    str_new_nxt     = str_new;
    str_closed_nxt  = str_closed;
    host_ready_nxt  = 1'b0;
    chardata_nxt    = 8'd0;
    isstring_nxt    = 1'b0;
    ispattern_nxt   = 1'b0;
    res_valid_nxt   = 1'b0;
    res_match_nxt   = res_match;
    res_index_nxt   = res_index;
    res_timeout_nxt = res_timeout;
`ifdef SME_TIMEOUT_EN
    cnt_nxt         = '0;
`endif
    case (state)
      LOAD: begin
        host_ready_nxt = 1'b1;
        if (str_acc) begin
          str_len_nxt    = str_wr ? str_base + LW'(1) : str_base;
          str_closed_nxt = host_last;
          str_new_nxt    = host_last ? 1'b1 : str_new;
        end else if (pat_acc) begin
          pat_len_nxt = pat_wr ? pat_len + LW'(1) : pat_len;
          if (host_last) begin
            host_ready_nxt = 1'b0;
            if (str_new) begin
              state_nxt    = SEND_STR;
              chardata_nxt = str_mem[0];
              isstring_nxt = 1'b1;
              idx_nxt      = LW'(1);
            end else if (str_len != '0) begin
              // A one-char pattern is still being written, so bypass the buffer.
              state_nxt     = SEND_PAT;
              chardata_nxt  = (pat_len == '0) ? host_char : pat_mem[0];
              ispattern_nxt = 1'b1;
              idx_nxt       = LW'(1);
            end else begin
              state_nxt       = RESULT;
              pat_len_nxt     = '0;
              res_valid_nxt   = 1'b1;
              res_match_nxt   = 1'b0;
              res_index_nxt   = 5'd0;
              res_timeout_nxt = 1'b0;
            end
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          state_nxt = LOAD;
        end
      end
      SEND_STR: begin
        if (idx < str_len) begin
          chardata_nxt = str_mem[idx[SAW-1:0]];
          isstring_nxt = 1'b1;
          idx_nxt      = idx + LW'(1);
        end else begin
          state_nxt     = SEND_PAT;
          str_new_nxt   = 1'b0;
          chardata_nxt  = pat_mem[0];
          ispattern_nxt = 1'b1;
          idx_nxt       = LW'(1);
        end
      end
      SEND_PAT: begin
        if (idx < pat_len) begin
          chardata_nxt  = pat_mem[idx[PAW-1:0]];
          ispattern_nxt = 1'b1;
          idx_nxt       = idx + LW'(1);
        end else begin
          state_nxt   = WAIT;
          pat_len_nxt = '0;
          idx_nxt     = '0;
        end
      end
      WAIT: begin
        if (valid) begin
          state_nxt       = RESULT;
          res_valid_nxt   = 1'b1;
          res_match_nxt   = match;
          res_index_nxt   = match_index;
          res_timeout_nxt = 1'b0;
        end
`ifdef SME_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt       = RESULT;
          res_valid_nxt   = 1'b1;
          res_match_nxt   = 1'b0;
          res_index_nxt   = 5'd0;
          res_timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
`else
        else begin
          state_nxt = WAIT;
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          state_nxt      = LOAD;
          host_ready_nxt = 1'b1;
        end else begin
          res_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt      = LOAD;
        host_ready_nxt = 1'b1;
      end
    endcase
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      idx         <= '0;
      str_len     <= '0;
      pat_len     <= '0;
      str_new     <= 1'b0;
      str_closed  <= 1'b1;
      host_ready  <= 1'b1;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_timeout <= 1'b0;
`ifdef SME_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      str_len     <= str_len_nxt;
      pat_len     <= pat_len_nxt;
      str_new     <= str_new_nxt;
      str_closed  <= str_closed_nxt;
      host_ready  <= host_ready_nxt;
      chardata    <= chardata_nxt;
      isstring    <= isstring_nxt;
      ispattern   <= ispattern_nxt;
      res_valid   <= res_valid_nxt;
      res_match   <= res_match_nxt;
      res_index   <= res_index_nxt;
      res_timeout <= res_timeout_nxt;
`ifdef SME_TIMEOUT_EN
      cnt         <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sme_req_seq.sv
// Directed bench for sme_req_seq: load/send sequencing, overflow, reset abort, no-string path and
// (with SME_TIMEOUT_EN) the WAIT watchdog at TIMEOUT_CYCLES=16.
module tb_sme_req_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic       host_wr, host_sel, host_last, host_ready;
  logic [7:0] host_char, chardata;
  logic       isstring, ispattern, valid, match;
  logic [4:0] match_index, res_index;
  logic       res_valid, res_ready, res_match, res_timeout;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  sme_req_seq #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .host_wr(host_wr), .host_sel(host_sel), .host_char(host_char),
    .host_last(host_last), .host_ready(host_ready), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [7:0] ch, input logic last);
    host_wr = 1'b1; host_sel = sel; host_char = ch; host_last = last;
    tick();
    host_wr = 1'b0; host_last = 1'b0;
  endtask

  task automatic sme_resp(input logic m, input logic [4:0] ix);
    valid = 1'b1; match = m; match_index = ix;
    tick();
    valid = 1'b0; match = 1'b0; match_index = 5'd0;
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("consume_res_valid", {31'd0, res_valid}, 32'd0);
    chk("consume_host_ready", {31'd0, host_ready}, 32'd1);
  endtask

  task automatic chk_drive(input string tag, input logic s, input logic p, input logic [7:0] c);
    chk({tag, "_isstring"}, {31'd0, isstring}, {31'd0, s});
    chk({tag, "_ispattern"}, {31'd0, ispattern}, {31'd0, p});
    chk({tag, "_chardata"}, {24'd0, chardata}, {24'd0, c});
  endtask

  initial begin
    reset = 1'b1; host_wr = 1'b0; host_sel = 1'b0; host_char = 8'd0; host_last = 1'b0;
    valid = 1'b0; match = 1'b0; match_index = 5'd0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_host_ready", {31'd0, host_ready}, 32'd1);
    chk_drive("rst", 1'b0, 1'b0, 8'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_match", {31'd0, res_match}, 32'd0);
    chk("rst_res_index", {27'd0, res_index}, 32'd0);
    chk("rst_res_timeout", {31'd0, res_timeout}, 32'd0);
    reset = 1'b0;

    // "abcde" then "cd": 5 string chars, 2 pattern chars, match at 2
    for (int i = 0; i < 5; i++) wr(1'b0, 8'h61 + 8'(i), i == 4);
    wr(1'b1, 8'h63, 1'b0);
    wr(1'b1, 8'h64, 1'b1);
    chk("t1_host_ready_drop", {31'd0, host_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk_drive("t1_str", 1'b1, 1'b0, 8'h61 + 8'(i));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk_drive("t1_pat", 1'b0, 1'b1, 8'h63 + 8'(i));
      tick();
    end
    chk_drive("t1_wait", 1'b0, 1'b0, 8'd0);
    chk("t1_wait_res_valid", {31'd0, res_valid}, 32'd0);
    sme_resp(1'b1, 5'd2);
    chk("t1_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t1_res_match", {31'd0, res_match}, 32'd1);
    chk("t1_res_index", {27'd0, res_index}, 32'd2);
    chk("t1_res_timeout", {31'd0, res_timeout}, 32'd0);
    sme_resp(1'b0, 5'd9);
    chk("t1_hold_valid", {31'd0, res_valid}, 32'd1);
    chk("t1_hold_match", {31'd0, res_match}, 32'd1);
    chk("t1_hold_index", {27'd0, res_index}, 32'd2);
    consume();

    // "zz" with no new string: pattern only
    wr(1'b1, 8'h7a, 1'b0);
    wr(1'b1, 8'h7a, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk_drive("t2_pat", 1'b0, 1'b1, 8'h7a);
      tick();
    end
    chk_drive("t2_wait", 1'b0, 1'b0, 8'd0);
    sme_resp(1'b0, 5'd7);
    chk("t2_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t2_res_match", {31'd0, res_match}, 32'd0);
    chk("t2_res_index", {27'd0, res_index}, 32'd7);
    consume();

    // 34-char string and 10-char pattern saturate at 32 and 8
    for (int i = 0; i < 34; i++) wr(1'b0, 8'h41 + 8'(i), i == 33);
    for (int i = 0; i < 10; i++) wr(1'b1, 8'h30 + 8'(i), i == 9);
    for (int i = 0; i < 32; i++) begin
      chk_drive("t3_str", 1'b1, 1'b0, 8'h41 + 8'(i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      chk_drive("t3_pat", 1'b0, 1'b1, 8'h30 + 8'(i));
      tick();
    end
    chk_drive("t3_wait", 1'b0, 1'b0, 8'd0);
    sme_resp(1'b1, 5'd31);
    chk("t3_res_match", {31'd0, res_match}, 32'd1);
    chk("t3_res_index", {27'd0, res_index}, 32'd31);
    consume();

    // reset in SEND_STR, then a lone pattern gives the no-string result
    wr(1'b0, 8'h78, 1'b0);
    wr(1'b0, 8'h79, 1'b1);
    wr(1'b1, 8'h71, 1'b1);
    chk_drive("t4_send", 1'b1, 1'b0, 8'h78);
    reset = 1'b1;
    #1;
    chk_drive("t4_rst", 1'b0, 1'b0, 8'd0);
    chk("t4_rst_host_ready", {31'd0, host_ready}, 32'd1);
    tick();
    reset = 1'b0;
    wr(1'b1, 8'h70, 1'b1);
    chk("t4_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t4_res_match", {31'd0, res_match}, 32'd0);
    chk("t4_res_index", {27'd0, res_index}, 32'd0);
    chk("t4_host_ready", {31'd0, host_ready}, 32'd0);
    chk_drive("t4_idle", 1'b0, 1'b0, 8'd0);
    consume();

    // single-char string and patterns
    wr(1'b0, 8'h6d, 1'b1);
    wr(1'b1, 8'h6b, 1'b1);
    chk_drive("t5_str", 1'b1, 1'b0, 8'h6d);
    tick();
    chk_drive("t5_pat", 1'b0, 1'b1, 8'h6b);
    tick();
    chk_drive("t5_wait", 1'b0, 1'b0, 8'd0);
    sme_resp(1'b1, 5'd0);
    chk("t5_res_match", {31'd0, res_match}, 32'd1);
    consume();
    wr(1'b1, 8'h77, 1'b1);
    chk_drive("t6_pat", 1'b0, 1'b1, 8'h77);
    tick();
    chk_drive("t6_wait", 1'b0, 1'b0, 8'd0);
`ifdef SME_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      chk("t6_wait_no_result", {31'd0, res_valid}, 32'd0);
      tick();
    end
    chk("t6_to_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t6_to_res_timeout", {31'd0, res_timeout}, 32'd1);
    chk("t6_to_res_match", {31'd0, res_match}, 32'd0);
    chk("t6_to_res_index", {27'd0, res_index}, 32'd0);
`else
    for (int k = 0; k < 40; k++) tick();
    chk("t6_hold_wait", {31'd0, res_valid}, 32'd0);
    sme_resp(1'b1, 5'd3);
    chk("t6_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t6_res_index", {27'd0, res_index}, 32'd3);
    chk("t6_res_timeout", {31'd0, res_timeout}, 32'd0);
`endif
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
